// File: rtl/fwd_hazard_pkg.sv
// Shared encodings and helpers for the forwarding/hazard unit.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
package fwd_hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam int CNT_W  = 4;
    localparam int STAT_W = 16;

    // Saturating add of a 0..2 increment onto a statistics counter.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [1:0]        inc);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + {{(STAT_W-1){1'b0}}, inc};
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// Per-operand forward select, load-use hazard detect and operand data mux.
// With en low the operand falls back to the register file value.
module fwd_operand_mux
    import fwd_hazard_pkg::*;
#(
    parameter int D_SIZE  = 32,
    parameter int R_ADDR  = 3,
    parameter int R0_ZERO = 0
) (
    input  logic              en,
    input  logic [R_ADDR-1:0] addr,
    input  logic              use_op,
    input  logic [D_SIZE-1:0] data_rd,
    input  logic [R_ADDR-1:0] dest_ex,
    input  logic              reg_we_ex,
    input  logic              mem_re_ex,
    input  logic [D_SIZE-1:0] result_ex,
    input  logic [R_ADDR-1:0] dest_wb,
    input  logic              reg_we_wb,
    input  logic [D_SIZE-1:0] result_wb,
    output logic [1:0]        sel,
    output logic [D_SIZE-1:0] op_fwd,
    output logic              hazard
);

    logic addr_ok_s;
    logic ex_match_s;
    logic wb_hit_s;

    // Match EX/WB destinations against this operand and pick the newest source.
    always_comb begin
        addr_ok_s  = !((R0_ZERO != 0) && (addr == {R_ADDR{1'b0}}));
        ex_match_s = use_op & addr_ok_s & reg_we_ex & (dest_ex == addr);
        wb_hit_s   = use_op & addr_ok_s & reg_we_wb & (dest_wb == addr);
        hazard     = en & ex_match_s & mem_re_ex;
        if (!en) begin
            sel = FWD_RF;
        end else if (ex_match_s && !mem_re_ex) begin
            sel = FWD_EX;
        end else if (wb_hit_s) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        case (sel)
            FWD_EX:  op_fwd = result_ex;
            FWD_WB:  op_fwd = result_wb;
            default: op_fwd = data_rd;
        endcase
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use stall control for the 4-stage pipeline.
// Define HAZARD_STATS_EN to build the stall/forward statistics counters.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int D_SIZE   = 32,
    parameter int R_ADDR   = 3,
    parameter int LOAD_LAT = 1,
    parameter int R0_ZERO  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [R_ADDR-1:0] addr_op1_rd,
    input  logic [R_ADDR-1:0] addr_op2_rd,
    input  logic              use_op1_rd,
    input  logic              use_op2_rd,
    input  logic [D_SIZE-1:0] data_op1_rd,
    input  logic [D_SIZE-1:0] data_op2_rd,
    input  logic [R_ADDR-1:0] dest_ex,
    input  logic              reg_we_ex,
    input  logic              mem_re_ex,
    input  logic [D_SIZE-1:0] result_ex,
    input  logic [R_ADDR-1:0] dest_wb,
    input  logic              reg_we_wb,
    input  logic [D_SIZE-1:0] result_wb,
    input  logic              flush,
    output logic [D_SIZE-1:0] op1_fwd,
    output logic [D_SIZE-1:0] op2_fwd,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              freeze,
    output logic              clear,
    output logic              stalled,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       fwd_cnt
);

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             haz1_s, haz2_s;

    fwd_operand_mux #(.D_SIZE(D_SIZE), .R_ADDR(R_ADDR), .R0_ZERO(R0_ZERO)) u_op1 (
        .en(rst), .addr(addr_op1_rd), .use_op(use_op1_rd), .data_rd(data_op1_rd),
        .dest_ex(dest_ex), .reg_we_ex(reg_we_ex), .mem_re_ex(mem_re_ex), .result_ex(result_ex),
        .dest_wb(dest_wb), .reg_we_wb(reg_we_wb), .result_wb(result_wb),
        .sel(fwd_sel1), .op_fwd(op1_fwd), .hazard(haz1_s)
    );

    fwd_operand_mux #(.D_SIZE(D_SIZE), .R_ADDR(R_ADDR), .R0_ZERO(R0_ZERO)) u_op2 (
        .en(rst), .addr(addr_op2_rd), .use_op(use_op2_rd), .data_rd(data_op2_rd),
        .dest_ex(dest_ex), .reg_we_ex(reg_we_ex), .mem_re_ex(mem_re_ex), .result_ex(result_ex),
        .dest_wb(dest_wb), .reg_we_wb(reg_we_wb), .result_wb(result_wb),
        .sel(fwd_sel2), .op_fwd(op2_fwd), .hazard(haz2_s)
    );

    // Stall FSM state and remaining-latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next state and stall controls; flush overrides any hazard or stall in progress.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        freeze      = 1'b0;
        clear       = 1'b0;
        if (!rst) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (flush) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
            clear       = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (haz1_s || haz2_s) begin
                        freeze = 1'b1;
                        clear  = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt_s = STALL;
                            cnt_nxt_s   = CNT_W'(LOAD_LAT - 1);
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                STALL: begin
                    freeze = 1'b1;
                    clear  = 1'b1;
                    if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign stalled = (state_r == STALL);

`ifdef HAZARD_STATS_EN
    logic [1:0] fwd_inc_s;
    logic       fwd1_s, fwd2_s;

    assign fwd1_s    = (fwd_sel1 != FWD_RF) & ~freeze;
    assign fwd2_s    = (fwd_sel2 != FWD_RF) & ~freeze;
    assign fwd_inc_s = {1'b0, fwd1_s} + {1'b0, fwd2_s};

    // Saturating statistics: freeze cycles and forwarded operands actually consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= {STAT_W{1'b0}};
            fwd_cnt   <= {STAT_W{1'b0}};
        end else begin
            stall_cnt <= sat_add(stall_cnt, {1'b0, freeze});
            fwd_cnt   <= sat_add(fwd_cnt, fwd_inc_s);
        end
    end
`else
    assign stall_cnt = {STAT_W{1'b0}};
    assign fwd_cnt   = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: dut_a uses LOAD_LAT=1/R0_ZERO=0, dut_b uses LOAD_LAT=3/R0_ZERO=1.
module tb_fwd_hazard_unit;

    localparam logic [31:0] D1  = 32'h1111_0001;
    localparam logic [31:0] D2  = 32'h2222_0002;
    localparam logic [31:0] REX = 32'hA5A5_0001;
    localparam logic [31:0] RWB = 32'h5A5A_0002;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr_op1_rd, addr_op2_rd, dest_ex, dest_wb;
    logic        use_op1_rd, use_op2_rd, reg_we_ex, mem_re_ex, reg_we_wb, flush;
    logic [31:0] data_op1_rd, data_op2_rd, result_ex, result_wb;

    logic [31:0] a_op1, a_op2, b_op1, b_op2;
    logic [1:0]  a_sel1, a_sel2, b_sel1, b_sel2;
    logic        a_freeze, a_clear, a_stalled, b_freeze, b_clear, b_stalled;
    logic [15:0] a_stall_cnt, a_fwd_cnt, b_stall_cnt, b_fwd_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.D_SIZE(32), .R_ADDR(3), .LOAD_LAT(1), .R0_ZERO(0)) dut_a (
        .clk(clk), .rst(rst),
        .addr_op1_rd(addr_op1_rd), .addr_op2_rd(addr_op2_rd),
        .use_op1_rd(use_op1_rd), .use_op2_rd(use_op2_rd),
        .data_op1_rd(data_op1_rd), .data_op2_rd(data_op2_rd),
        .dest_ex(dest_ex), .reg_we_ex(reg_we_ex), .mem_re_ex(mem_re_ex), .result_ex(result_ex),
        .dest_wb(dest_wb), .reg_we_wb(reg_we_wb), .result_wb(result_wb), .flush(flush),
        .op1_fwd(a_op1), .op2_fwd(a_op2), .fwd_sel1(a_sel1), .fwd_sel2(a_sel2),
        .freeze(a_freeze), .clear(a_clear), .stalled(a_stalled),
        .stall_cnt(a_stall_cnt), .fwd_cnt(a_fwd_cnt)
    );

    fwd_hazard_unit #(.D_SIZE(32), .R_ADDR(3), .LOAD_LAT(3), .R0_ZERO(1)) dut_b (
        .clk(clk), .rst(rst),
        .addr_op1_rd(addr_op1_rd), .addr_op2_rd(addr_op2_rd),
        .use_op1_rd(use_op1_rd), .use_op2_rd(use_op2_rd),
        .data_op1_rd(data_op1_rd), .data_op2_rd(data_op2_rd),
        .dest_ex(dest_ex), .reg_we_ex(reg_we_ex), .mem_re_ex(mem_re_ex), .result_ex(result_ex),
        .dest_wb(dest_wb), .reg_we_wb(reg_we_wb), .result_wb(result_wb), .flush(flush),
        .op1_fwd(b_op1), .op2_fwd(b_op2), .fwd_sel1(b_sel1), .fwd_sel2(b_sel2),
        .freeze(b_freeze), .clear(b_clear), .stalled(b_stalled),
        .stall_cnt(b_stall_cnt), .fwd_cnt(b_fwd_cnt)
    );

    typedef struct {
        logic [2:0]  a1, a2;
        logic        u1, u2;
        logic [2:0]  dex;
        logic        wex;
        logic [2:0]  dwb;
        logic        wwb;
        logic [1:0]  s1, s2;
        logic [31:0] o1, o2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic quiet();
        addr_op1_rd = 3'd1; addr_op2_rd = 3'd2; use_op1_rd = 1'b0; use_op2_rd = 1'b0;
        dest_ex = 3'd0; reg_we_ex = 1'b0; mem_re_ex = 1'b0;
        dest_wb = 3'd0; reg_we_wb = 1'b0; flush = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_hazard_r5();
        addr_op1_rd = 3'd5; use_op1_rd = 1'b1;
        dest_ex = 3'd5; reg_we_ex = 1'b1; mem_re_ex = 1'b1;
    endtask

    task automatic bubble_wb_r5();
        dest_ex = 3'd0; reg_we_ex = 1'b0; mem_re_ex = 1'b0;
        dest_wb = 3'd5; reg_we_wb = 1'b1;
    endtask

    initial begin
        data_op1_rd = D1; data_op2_rd = D2; result_ex = REX; result_wb = RWB;
        vecs[0] = '{3'd3, 3'd1, 1'b1, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 2'b01, 2'b00, REX, D2};
        vecs[1] = '{3'd4, 3'd2, 1'b1, 1'b1, 3'd2, 1'b0, 3'd2, 1'b1, 2'b00, 2'b10, D1,  RWB};
        vecs[2] = '{3'd4, 3'd2, 1'b1, 1'b0, 3'd2, 1'b0, 3'd2, 1'b1, 2'b00, 2'b00, D1,  D2};
        vecs[3] = '{3'd6, 3'd6, 1'b1, 1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 2'b01, 2'b01, REX, REX};
        vecs[4] = '{3'd7, 3'd6, 1'b1, 1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 2'b10, 2'b01, RWB, REX};
        vecs[5] = '{3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 2'b01, 2'b01, REX, REX};
        vecs[6] = '{3'd1, 3'd2, 1'b1, 1'b1, 3'd1, 1'b0, 3'd2, 1'b0, 2'b00, 2'b00, D1,  D2};
        vecs[7] = '{3'd5, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 2'b00, 2'b01, D1,  REX};

        // Reset: outputs forced to regfile/no-stall even with matching forwards present.
        rst = 1'b0;
        quiet();
        addr_op1_rd = 3'd3; use_op1_rd = 1'b1; dest_ex = 3'd3; reg_we_ex = 1'b1;
        #2;
        check("rst_sel1", {30'd0, a_sel1}, 32'd0);
        check("rst_op1", a_op1, D1);
        check("rst_freeze", {31'd0, a_freeze}, 32'd0);
        check("rst_clear", {31'd0, a_clear}, 32'd0);
        check("rst_stalled", {31'd0, b_stalled}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        quiet();
        next_cycle();

        // Combinational forwarding table.
        for (int i = 0; i < 8; i++) begin
            addr_op1_rd = vecs[i].a1; addr_op2_rd = vecs[i].a2;
            use_op1_rd = vecs[i].u1; use_op2_rd = vecs[i].u2;
            dest_ex = vecs[i].dex; reg_we_ex = vecs[i].wex; mem_re_ex = 1'b0;
            dest_wb = vecs[i].dwb; reg_we_wb = vecs[i].wwb;
            @(negedge clk);
            check($sformatf("v%0d_sel1", i), {30'd0, a_sel1}, {30'd0, vecs[i].s1});
            check($sformatf("v%0d_sel2", i), {30'd0, a_sel2}, {30'd0, vecs[i].s2});
            check($sformatf("v%0d_op1", i), a_op1, vecs[i].o1);
            check($sformatf("v%0d_op2", i), a_op2, vecs[i].o2);
            check($sformatf("v%0d_freeze", i), {31'd0, a_freeze}, 32'd0);
            check($sformatf("v%0d_b_sel1", i), {30'd0, b_sel1},
                  (vecs[i].a1 == 3'd0) ? 32'd0 : {30'd0, vecs[i].s1});
            next_cycle();
        end
        quiet();
        next_cycle();

        // Load-use: one freeze cycle on dut_a, three on dut_b.
        load_hazard_r5();
        @(negedge clk);
        check("ll1_freeze", {31'd0, a_freeze}, 32'd1);
        check("ll1_clear", {31'd0, a_clear}, 32'd1);
        check("ll1_stalled", {31'd0, a_stalled}, 32'd0);
        check("ll3_c1_freeze", {31'd0, b_freeze}, 32'd1);
        check("ll3_c1_stalled", {31'd0, b_stalled}, 32'd0);
        next_cycle();
        bubble_wb_r5();
        @(negedge clk);
        check("ll1_c2_freeze", {31'd0, a_freeze}, 32'd0);
        check("ll1_c2_sel1", {30'd0, a_sel1}, 32'd2);
        check("ll1_c2_op1", a_op1, RWB);
        check("ll1_c2_stalled", {31'd0, a_stalled}, 32'd0);
        check("ll3_c2_freeze", {31'd0, b_freeze}, 32'd1);
        check("ll3_c2_stalled", {31'd0, b_stalled}, 32'd1);
        check("ll3_c2_sel1", {30'd0, b_sel1}, 32'd2);
        next_cycle();
        @(negedge clk);
        check("ll3_c3_freeze", {31'd0, b_freeze}, 32'd1);
        check("ll3_c3_clear", {31'd0, b_clear}, 32'd1);
        check("ll3_c3_stalled", {31'd0, b_stalled}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("ll3_c4_freeze", {31'd0, b_freeze}, 32'd0);
        check("ll3_c4_stalled", {31'd0, b_stalled}, 32'd0);
        quiet();
        next_cycle();

        // Flush during STALL aborts the remaining stall.
        load_hazard_r5();
        next_cycle();
        bubble_wb_r5();
        flush = 1'b1;
        @(negedge clk);
        check("fl_c2_freeze", {31'd0, b_freeze}, 32'd0);
        check("fl_c2_clear", {31'd0, b_clear}, 32'd1);
        check("fl_c2_stalled", {31'd0, b_stalled}, 32'd1);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("fl_c3_freeze", {31'd0, b_freeze}, 32'd0);
        check("fl_c3_stalled", {31'd0, b_stalled}, 32'd0);
        check("fl_c3_clear", {31'd0, b_clear}, 32'd0);
        quiet();
        next_cycle();

        // Flush beats a fresh hazard in IDLE.
        load_hazard_r5();
        flush = 1'b1;
        @(negedge clk);
        check("fli_freeze", {31'd0, a_freeze}, 32'd0);
        check("fli_clear", {31'd0, a_clear}, 32'd1);
        check("fli_b_freeze", {31'd0, b_freeze}, 32'd0);
        next_cycle();
        quiet();
        @(negedge clk);
        check("fli_b_stalled", {31'd0, b_stalled}, 32'd0);
        next_cycle();

        // Register 0 handling.
        addr_op1_rd = 3'd0; use_op1_rd = 1'b1; dest_ex = 3'd0; reg_we_ex = 1'b1;
        @(negedge clk);
        check("r0_b_sel1", {30'd0, b_sel1}, 32'd0);
        check("r0_b_op1", b_op1, D1);
        check("r0_a_sel1", {30'd0, a_sel1}, 32'd1);
        mem_re_ex = 1'b1;
        #1;
        check("r0_b_freeze", {31'd0, b_freeze}, 32'd0);
        check("r0_a_freeze", {31'd0, a_freeze}, 32'd1);
        next_cycle();
        quiet();
        next_cycle();

        // Asynchronous reset in the middle of a stall.
        load_hazard_r5();
        next_cycle();
        bubble_wb_r5();
        #1;
        check("mr_pre_stalled", {31'd0, b_stalled}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mr_freeze", {31'd0, b_freeze}, 32'd0);
        check("mr_clear", {31'd0, b_clear}, 32'd0);
        check("mr_stalled", {31'd0, b_stalled}, 32'd0);
        check("mr_sel1", {30'd0, b_sel1}, 32'd0);
        check("mr_op1", b_op1, D1);
        check("mr_stall_cnt", {16'd0, b_stall_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        quiet();
        next_cycle();

        // Statistics: two forwards in one cycle, then one freeze cycle on dut_a.
        addr_op1_rd = 3'd6; addr_op2_rd = 3'd6; use_op1_rd = 1'b1; use_op2_rd = 1'b1;
        dest_ex = 3'd6; reg_we_ex = 1'b1;
        next_cycle();
        quiet();
        load_hazard_r5();
        next_cycle();
        quiet();
        @(negedge clk);
`ifdef HAZARD_STATS_EN
        check("st_fwd_cnt", {16'd0, a_fwd_cnt}, 32'd2);
        check("st_stall_cnt", {16'd0, a_stall_cnt}, 32'd1);
`else
        check("st_fwd_cnt", {16'd0, a_fwd_cnt}, 32'd0);
        check("st_stall_cnt", {16'd0, a_stall_cnt}, 32'd0);
        check("st_b_stall_cnt", {16'd0, b_stall_cnt}, 32'd0);
`endif
        repeat (4) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
